// File: rtl/rgb_compare_pwm.sv
// Unsigned A/B comparator that drives one RGB LED with the result colour.
// Brightness comes from a free-running PWM counter. An optional blink gate toggles every BLINK_PERIODS PWM periods.
module rgb_compare_pwm #(
  parameter int WIDTH         = 4,
  parameter int PWM_BITS      = 4,
  parameter int BLINK_PERIODS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                in_valid,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                blink_en,
  input  logic                clear,
  output logic                red,
  output logic                green,
  output logic                blue,
  output logic [1:0]          cmp_code,
  output logic                active
);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  localparam int PC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_RED   = 2'b01;
  localparam logic [1:0] CODE_GREEN = 2'b10;
  localparam logic [1:0] CODE_BLUE  = 2'b11;

  state_t              r_state;
  logic [1:0]          r_cmp_code;
  logic [PWM_BITS-1:0] r_duty_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PC_W-1:0]     r_period_cnt;
  logic                r_phase;

  logic w_wrap;
  logic w_accept;
  logic w_pwm_on;
  logic w_lit;

  function automatic logic [1:0] compare_code(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    if (x > y)       return CODE_RED;
    else if (x == y) return CODE_GREEN;
    else             return CODE_BLUE;
  endfunction

  assign w_wrap   = (r_pwm_cnt == '1);
  // clear has priority: a simultaneous load is dropped entirely.
  assign w_accept = in_valid && !clear;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmp_code   <= CODE_NONE;
      r_duty_q     <= '0;
      r_pwm_cnt    <= '0;
      r_period_cnt <= '0;
      r_phase      <= 1'b1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);

      if (clear) begin
        r_state    <= S_IDLE;
        r_cmp_code <= CODE_NONE;
        r_duty_q   <= '0;
      end else if (in_valid) begin
        r_state    <= S_ACTIVE;
        r_cmp_code <= compare_code(a, b);
        r_duty_q   <= duty;
      end

      // A load restarts the blink sequence in the visible phase.
      if (w_accept) begin
        r_period_cnt <= '0;
        r_phase      <= 1'b1;
      end else if (w_wrap) begin
        if (r_period_cnt == PC_W'(BLINK_PERIODS - 1)) begin
          r_period_cnt <= '0;
          r_phase      <= ~r_phase;
        end else begin
          r_period_cnt <= r_period_cnt + PC_W'(1);
        end
      end
    end
  end

  // Outputs decode registered state and blink_en only.
  assign w_pwm_on = (r_pwm_cnt < r_duty_q);
  assign active   = (r_state == S_ACTIVE);
  assign cmp_code = r_cmp_code;
  assign w_lit    = active && w_pwm_on && (!blink_en || r_phase);
  assign red      = w_lit && (r_cmp_code == CODE_RED);
  assign green    = w_lit && (r_cmp_code == CODE_GREEN);
  assign blue     = w_lit && (r_cmp_code == CODE_BLUE);

endmodule
